// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding, default width and counter sizing.
// Rev 1.0
`default_nettype none

package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter only needs to reach N-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit gate-level cell, d = x - y - z, bo = borrow out.
// Rev 1.0
`default_nettype none

module full_subtractor (
  input  wire x,
  input  wire y,
  input  wire z,
  output wire d,
  output wire bo
);

  wire x_n;
  wire x_xor_y;
  wire x_xnor_y;
  wire borrow_xy;
  wire borrow_z;

  not g_not_x   (x_n, x);
  xor g_xor_xy  (x_xor_y, x, y);
  xor g_xor_d   (d, x_xor_y, z);
  and g_and_xy  (borrow_xy, x_n, y);
  not g_not_xy  (x_xnor_y, x_xor_y);
  and g_and_z   (borrow_z, x_xnor_y, z);
  or  g_or_bo   (bo, borrow_xy, borrow_z);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock.
// Rev 1.0
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  res_sr;
  logic          borrow;
  logic [CW-1:0] cnt;
  wire           d;
  wire           bo;

  full_subtractor u_cell (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .z  (borrow),
    .d  (d),
    .bo (bo)
  );

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d, res_sr[N-1:1]};
          borrow <= bo;
          if (cnt == LAST) begin
            // On the last bit the cell inputs are the original operand MSBs.
            diff  <= {d, res_sr[N-1:1]};
            bout  <= bo;
            ovf   <= (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
